prio_arb_n: RTL and testbench

Parametrised command-priority arbiter between the requester hold stages and the two ALU groups of the calculator.
- Each of NUM_PORTS requesters gets a one-deep command register.
- Pending commands are steered by opcode class: add/sub class to ALU1, shift class to ALU2.
- Each channel grants one requester at a time with fixed or round-robin priority, over a valid/ready handshake.
- Unlike the previous generation, it adds backpressure, selectable fairness and per-port overflow detection.

---
 rtl/prio_arb_n_if.sv | 35 +++
 rtl/prio_arb_n.sv | 159 +++++++++++++++
 tb/tb_prio_arb_n.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/prio_arb_n_if.sv
// rtl/prio_arb_n_if.sv - request/presentation bundle between hold stages and the two ALU channels
interface prio_arb_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = 4
);
  localparam int ID_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS*CMD_W-1:0] hold_prio_req;
  logic                       alu1_rdy;
  logic                       alu2_rdy;
  logic                       prio_alu1_out_vld;
  logic                       prio_alu2_out_vld;
  logic [ID_W-1:0]            prio_alu1_out_req_id;
  logic [ID_W-1:0]            prio_alu2_out_req_id;
  logic [CMD_W-1:0]           prio_alu1_in_cmd;
  logic [CMD_W-1:0]           prio_alu2_in_cmd;
  logic [NUM_PORTS-1:0]       pend_mask;
  logic [NUM_PORTS-1:0]       overflow_err;

  modport slave (
    input  hold_prio_req, alu1_rdy, alu2_rdy,
    output prio_alu1_out_vld, prio_alu2_out_vld,
    output prio_alu1_out_req_id, prio_alu2_out_req_id,
    output prio_alu1_in_cmd, prio_alu2_in_cmd,
    output pend_mask, overflow_err
  );

  modport master (
    output hold_prio_req, alu1_rdy, alu2_rdy,
    input  prio_alu1_out_vld, prio_alu2_out_vld,
    input  prio_alu1_out_req_id, prio_alu2_out_req_id,
    input  prio_alu1_in_cmd, prio_alu2_in_cmd,
    input  pend_mask, overflow_err
  );
endinterface

// File: rtl/prio_arb_n.sv
// rtl/prio_arb_n.sv - per-port command hold with two-channel fixed/round-robin arbiter
// Channel 0 drives ALU1 (commands 1..SPLIT), channel 1 drives ALU2 (above SPLIT).
module prio_arb_n #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = 4,
  parameter int SPLIT     = 3,
  parameter int RR_MODE   = 0
) (
  input logic          c_clk,
  input logic          reset,
  prio_arb_n_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int IW1  = ID_W + 1;
  localparam int NCH  = 2;
  localparam logic [CMD_W-1:0] SPLIT_C = CMD_W'(SPLIT);
  localparam logic [IW1-1:0]   NP_C    = IW1'(NUM_PORTS);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PORTS - 1);

  // per-port hold state
  logic [CMD_W-1:0]     cmd_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] reissue;
  logic [NUM_PORTS-1:0] ovf;

  // per-channel presentation stage and round-robin pointer
  logic [NCH-1:0]       vld_q;
  logic [ID_W-1:0]      id_q  [NCH];
  logic [CMD_W-1:0]     pcmd_q [NCH];
  logic [ID_W-1:0]      ptr_q [NCH];

  logic [NCH-1:0]       rdy;
  logic [NUM_PORTS-1:0] req_nz;
  logic [NUM_PORTS-1:0] presented;
  logic [NUM_PORTS-1:0] acc_port;
  logic [NUM_PORTS-1:0] elig [NCH];
  logic [NCH-1:0]       win_vld;
  logic [ID_W-1:0]      win_id [NCH];

  assign rdy = {bus.alu2_rdy, bus.alu1_rdy};

  // a nonzero slice is a request for that port
  always_comb begin
    req_nz = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_nz[i] = |bus.hold_prio_req[i*CMD_W +: CMD_W];
    end
  end

  // which ports sit in a presentation stage, and which of those retire this cycle
  always_comb begin
    presented = '0;
    acc_port  = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (vld_q[c] && id_q[c] == ID_W'(i)) begin
          presented[i] = 1'b1;
          if (rdy[c]) acc_port[i] = 1'b1;
        end
      end
    end
  end

  // eligibility by command class; a presented port is never offered again, which
  // also keeps a port off both channels when an overwrite changes its class
  always_comb begin
    for (int c = 0; c < NCH; c++) elig[c] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[0][i] = pend[i] && !presented[i] && (cmd_q[i] != '0) && (cmd_q[i] <= SPLIT_C);
      elig[1][i] = pend[i] && !presented[i] && (cmd_q[i] > SPLIT_C);
    end
  end

  // winner search starting at the pointer (or port 0 in fixed mode), wrapping modulo NUM_PORTS
  always_comb begin
    logic [IW1-1:0]  sum;
    logic [ID_W-1:0] start;
    logic [ID_W-1:0] idx;
    sum   = '0;
    start = '0;
    idx   = '0;
    for (int c = 0; c < NCH; c++) begin
      win_vld[c] = 1'b0;
      win_id[c]  = '0;
      start = (RR_MODE != 0) ? ptr_q[c] : '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        sum = {1'b0, start} + IW1'(off);
        if (sum >= NP_C) sum = sum - NP_C;
        idx = sum[ID_W-1:0];
        if (!win_vld[c] && elig[c][idx]) begin
          win_vld[c] = 1'b1;
          win_id[c]  = idx;
        end
      end
    end
  end

  // per-port command register, pending flag, overwrite tracking and sticky overflow
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) cmd_q[i] <= '0;
      pend    <= '0;
      reissue <= '0;
      ovf     <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_nz[i]) begin
          cmd_q[i] <= bus.hold_prio_req[i*CMD_W +: CMD_W];
          pend[i]  <= 1'b1;
          if (pend[i] && !acc_port[i]) ovf[i] <= 1'b1;
          // overwrite under a stalled presentation: the new command must survive the accept
          reissue[i] <= presented[i] && !acc_port[i];
        end else if (acc_port[i]) begin
          reissue[i] <= 1'b0;
          if (!reissue[i]) begin
            pend[i]  <= 1'b0;
            cmd_q[i] <= '0;
          end
        end
      end
    end
  end

  // presentation stage: hold while stalled, otherwise load the next winner or go idle
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      vld_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        id_q[c]   <= '0;
        pcmd_q[c] <= '0;
        ptr_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (!vld_q[c] || rdy[c]) begin
          vld_q[c] <= win_vld[c];
          if (win_vld[c]) begin
            id_q[c]   <= win_id[c];
            pcmd_q[c] <= cmd_q[win_id[c]];
            ptr_q[c]  <= (win_id[c] == LAST_ID) ? '0 : win_id[c] + 1'b1;
          end else begin
            id_q[c]   <= '0;
            pcmd_q[c] <= '0;
          end
        end
      end
    end
  end

  assign bus.prio_alu1_out_vld    = vld_q[0];
  assign bus.prio_alu2_out_vld    = vld_q[1];
  assign bus.prio_alu1_out_req_id = id_q[0];
  assign bus.prio_alu2_out_req_id = id_q[1];
  assign bus.prio_alu1_in_cmd     = pcmd_q[0];
  assign bus.prio_alu2_in_cmd     = pcmd_q[1];
  assign bus.pend_mask            = pend;
  assign bus.overflow_err         = ovf;

endmodule

// File: tb/tb_prio_arb_n.sv
// tb/tb_prio_arb_n.sv - directed bench for prio_arb_n, fixed and round-robin instances
module tb_prio_arb_n;
  localparam int NP = 4;
  localparam int CW = 4;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 c_clk = ~c_clk;

  prio_arb_n_if #(.NUM_PORTS(NP), .CMD_W(CW)) bf ();
  prio_arb_n_if #(.NUM_PORTS(NP), .CMD_W(CW)) br ();

  prio_arb_n #(.NUM_PORTS(NP), .CMD_W(CW), .SPLIT(3), .RR_MODE(0)) dut_fp (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bf.slave)
  );

  prio_arb_n #(.NUM_PORTS(NP), .CMD_W(CW), .SPLIT(3), .RR_MODE(1)) dut_rr (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (br.slave)
  );

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_req(input logic [NP*CW-1:0] v);
    bf.hold_prio_req = v;
    br.hold_prio_req = v;
  endtask

  task automatic set_rdy(input logic a1, input logic a2);
    bf.alu1_rdy = a1;
    br.alu1_rdy = a1;
    bf.alu2_rdy = a2;
    br.alu2_rdy = a2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NP*CW-1:0] rq;
    set_req('0);
    set_rdy(1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();

    // reset state
    chk("rst_pend", bf.pend_mask, 32'h0);
    chk("rst_vld1", bf.prio_alu1_out_vld, 32'h0);
    chk("rst_vld2", bf.prio_alu2_out_vld, 32'h0);
    chk("rst_ovf", bf.overflow_err, 32'h0);
    reset = 1'b1;

    // single command: port 2, cmd 1
    set_rdy(1'b1, 1'b0);
    set_req(16'h0100);
    step();
    set_req('0);
    chk("t1_pend", bf.pend_mask, 32'b0100);
    chk("t1_vld_early", bf.prio_alu1_out_vld, 32'h0);
    step();
    chk("t1_vld", bf.prio_alu1_out_vld, 32'h1);
    chk("t1_id", bf.prio_alu1_out_req_id, 32'd2);
    chk("t1_cmd", bf.prio_alu1_in_cmd, 32'd1);
    step();
    chk("t1_vld_done", bf.prio_alu1_out_vld, 32'h0);
    chk("t1_pend_done", bf.pend_mask, 32'h0);

    // split and concurrency: ports 0..3 get 1,5,2,6
    set_rdy(1'b1, 1'b1);
    set_req(16'h6251);
    step();
    set_req('0);
    chk("t2_pend", bf.pend_mask, 32'b1111);
    step();
    chk("t2_a1_vld0", bf.prio_alu1_out_vld, 32'h1);
    chk("t2_a1_id0", bf.prio_alu1_out_req_id, 32'd0);
    chk("t2_a1_cmd0", bf.prio_alu1_in_cmd, 32'd1);
    chk("t2_a2_vld0", bf.prio_alu2_out_vld, 32'h1);
    chk("t2_a2_id0", bf.prio_alu2_out_req_id, 32'd1);
    chk("t2_a2_cmd0", bf.prio_alu2_in_cmd, 32'd5);
    chk("t2_rr_a1_id0", br.prio_alu1_out_req_id, 32'd0);
    step();
    chk("t2_a1_id1", bf.prio_alu1_out_req_id, 32'd2);
    chk("t2_a1_cmd1", bf.prio_alu1_in_cmd, 32'd2);
    chk("t2_a2_id1", bf.prio_alu2_out_req_id, 32'd3);
    chk("t2_a2_cmd1", bf.prio_alu2_in_cmd, 32'd6);
    chk("t2_rr_a2_id1", br.prio_alu2_out_req_id, 32'd3);
    step();
    chk("t2_a1_idle", bf.prio_alu1_out_vld, 32'h0);
    chk("t2_a2_idle", bf.prio_alu2_out_vld, 32'h0);
    chk("t2_pend_done", bf.pend_mask, 32'h0);

    // backpressure: port 1 held on ALU1 for 5 cycles
    set_rdy(1'b0, 1'b0);
    set_req(16'h0020);
    step();
    set_req('0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t3_vld", bf.prio_alu1_out_vld, 32'h1);
      chk("t3_id", bf.prio_alu1_out_req_id, 32'd1);
      chk("t3_cmd", bf.prio_alu1_in_cmd, 32'd2);
      chk("t3_pend", bf.pend_mask, 32'b0010);
      step();
    end
    set_rdy(1'b1, 1'b0);
    step();
    chk("t3_vld_done", bf.prio_alu1_out_vld, 32'h0);
    chk("t3_pend_done", bf.pend_mask, 32'h0);

    // overflow: port 3 cmd 4 stalled on ALU2, then cmd 7
    set_rdy(1'b0, 1'b0);
    set_req(16'h4000);
    step();
    set_req('0);
    chk("t5_pend", bf.pend_mask, 32'b1000);
    chk("t5_ovf0", bf.overflow_err, 32'h0);
    step();
    chk("t5_vld", bf.prio_alu2_out_vld, 32'h1);
    chk("t5_id", bf.prio_alu2_out_req_id, 32'd3);
    chk("t5_cmd", bf.prio_alu2_in_cmd, 32'd4);
    set_req(16'h7000);
    step();
    set_req('0);
    chk("t5_ovf", bf.overflow_err, 32'b1000);
    chk("t5_cmd_held", bf.prio_alu2_in_cmd, 32'd4);
    chk("t5_a1_quiet", bf.prio_alu1_out_vld, 32'h0);
    step();
    chk("t5_ovf_sticky", bf.overflow_err, 32'b1000);
    chk("t5_cmd_held2", bf.prio_alu2_in_cmd, 32'd4);
    set_rdy(1'b0, 1'b1);
    step();
    chk("t5_gap_vld", bf.prio_alu2_out_vld, 32'h0);
    chk("t5_gap_pend", bf.pend_mask, 32'b1000);
    step();
    chk("t5_re_vld", bf.prio_alu2_out_vld, 32'h1);
    chk("t5_re_id", bf.prio_alu2_out_req_id, 32'd3);
    chk("t5_re_cmd", bf.prio_alu2_in_cmd, 32'd7);
    step();
    chk("t5_done_vld", bf.prio_alu2_out_vld, 32'h0);
    chk("t5_done_pend", bf.pend_mask, 32'h0);
    chk("t5_done_ovf", bf.overflow_err, 32'b1000);

    // reset while both channels are presenting
    set_rdy(1'b0, 1'b0);
    set_req(16'h0051);
    step();
    set_req('0);
    step();
    chk("t6_pre_vld1", bf.prio_alu1_out_vld, 32'h1);
    chk("t6_pre_vld2", bf.prio_alu2_out_vld, 32'h1);
    reset = 1'b0;
    step();
    chk("t6_vld1", bf.prio_alu1_out_vld, 32'h0);
    chk("t6_vld2", bf.prio_alu2_out_vld, 32'h0);
    chk("t6_id1", bf.prio_alu1_out_req_id, 32'h0);
    chk("t6_id2", bf.prio_alu2_out_req_id, 32'h0);
    chk("t6_cmd1", bf.prio_alu1_in_cmd, 32'h0);
    chk("t6_cmd2", bf.prio_alu2_in_cmd, 32'h0);
    chk("t6_pend", bf.pend_mask, 32'h0);
    chk("t6_ovf", bf.overflow_err, 32'h0);
    reset = 1'b1;
    set_rdy(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_post_vld1", bf.prio_alu1_out_vld, 32'h0);
      chk("t6_post_vld2", bf.prio_alu2_out_vld, 32'h0);
      chk("t6_post_pend", bf.pend_mask, 32'h0);
    end

    // fairness: every port requests cmd 2, each accepted port re-requests at once
    set_rdy(1'b1, 1'b0);
    set_req(16'h2222);
    step();
    set_req('0);
    step();
    for (int g = 0; g < 8; g++) begin
      // fixed priority keeps returning to port 0 as soon as it is eligible again
      chk("t4_fp_vld", bf.prio_alu1_out_vld, 32'h1);
      chk("t4_fp_id", bf.prio_alu1_out_req_id, 32'(g % 2));
      chk("t4_rr_vld", br.prio_alu1_out_vld, 32'h1);
      chk("t4_rr_id", br.prio_alu1_out_req_id, 32'(g % 4));
      rq = '0;
      rq[(g % 2)*CW +: CW] = 4'd2;
      bf.hold_prio_req = rq;
      rq = '0;
      rq[(g % 4)*CW +: CW] = 4'd2;
      br.hold_prio_req = rq;
      step();
    end
    set_req('0);
    chk("t4_fp_no_ovf", bf.overflow_err, 32'h0);
    chk("t4_rr_no_ovf", br.overflow_err, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
